// File: rtl/eforth1_pkg.sv
// eForth1 stack engine shared types and pointer helpers.
// Build option: STACK_GUARD_EN enables overflow/underflow/bad-pick rejection.
package eforth1_pkg;

    typedef enum logic [1:0] {
        SS_PUSH = 2'd0,
        SS_POP  = 2'd1,
        SS_SET  = 2'd2,
        SS_PICK = 2'd3
    } sop_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PICK  = 2'd2
    } ss_fsm_e;

    localparam int unsigned SP_MAXW = 16;

    function automatic logic [SP_MAXW-1:0] sp_mask(
        input int unsigned ssz
    );
        return (SP_MAXW'(1) << ssz) - SP_MAXW'(1);
    endfunction

    function automatic logic [SP_MAXW-1:0] sp_inc(
        input logic [SP_MAXW-1:0] p,
        input int unsigned        ssz
    );
        return (p + SP_MAXW'(1)) & sp_mask(ssz);
    endfunction

    function automatic logic [SP_MAXW-1:0] sp_dec(
        input logic [SP_MAXW-1:0] p,
        input int unsigned        ssz
    );
        return (p - SP_MAXW'(1)) & sp_mask(ssz);
    endfunction

endpackage

// File: rtl/ss_ram.sv
// Stack storage: 1R1W synchronous array, registered read data.
// Build option: none (STACK_GUARD_EN affects only the top level).
module ss_ram #(
    parameter  int DEPTH = 64,
    parameter  int DSZ   = 16,
    localparam int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [SSZ-1:0] wa,
    input  logic [DSZ-1:0] wd,
    input  logic [SSZ-1:0] ra,
    output logic [DSZ-1:0] rdata
);

    logic [DSZ-1:0] mem [DEPTH];

    // write port and one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rdata <= mem[ra];
    end

endmodule

// File: rtl/eforth1_stack.sv
// Stack engine for the ss_io protocol: FSM, sp0/sp1 pointers, NOS register.
// Build option: STACK_GUARD_EN rejects PUSH-full, POP/SET-empty, PICK>=cnt.
import eforth1_pkg::*;

module eforth1_stack #(
    parameter  int DEPTH = 64,
    parameter  int DSZ   = 16,
    localparam int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [1:0]     op,
    input  logic [DSZ-1:0] vi,
    output logic           rdy,
    output logic           done,
    output logic [DSZ-1:0] s,
    output logic [DSZ-1:0] po,
    output logic [SSZ-1:0] sp0,
    output logic [SSZ-1:0] sp1,
    output logic [SSZ:0]   cnt,
    output logic           full,
    output logic           empty,
    output logic           err
);

    ss_fsm_e        state_q, state_d;
    logic [SSZ-1:0] sp0_q, sp0_d;
    logic [SSZ-1:0] sp1_q, sp1_d;
    logic [SSZ:0]   cnt_q, cnt_d;
    logic [DSZ-1:0] s_q, s_d;
    logic [DSZ-1:0] po_q, po_d;
    logic           done_q, done_d;

    logic           we;
    logic [SSZ-1:0] wa;
    logic [DSZ-1:0] wd;
    logic [SSZ-1:0] ra;
    logic [DSZ-1:0] rdata;

    logic [SSZ-1:0] sp0_dec;
    logic [SSZ-1:0] sp1_inc;
    sop_e           sop;
    logic           accept;
    logic           reject;
    logic           is_full;
    logic           is_empty;

    ss_ram #(
        .DEPTH (DEPTH),
        .DSZ   (DSZ)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra),
        .rdata (rdata)
    );

    assign sop      = sop_e'(op);
    assign sp0_dec  = SSZ'(sp_dec(SP_MAXW'(sp0_q), SSZ));
    assign sp1_inc  = SSZ'(sp_inc(SP_MAXW'(sp1_q), SSZ));
    assign is_full  = (cnt_q == (SSZ+1)'(DEPTH));
    assign is_empty = (cnt_q == '0);
    assign accept   = req && (state_q == IDLE);

`ifdef STACK_GUARD_EN
    logic guard_bad;
    logic err_q;

    // an op that would corrupt the stack is refused up front
    always_comb begin
        guard_bad = 1'b0;
        unique case (sop)
            SS_PUSH: guard_bad = is_full;
            SS_POP:  guard_bad = is_empty;
            SS_SET:  guard_bad = is_empty;
            SS_PICK: guard_bad = (32'(vi) >= 32'(cnt_q));
        endcase
    end

    assign reject = accept && guard_bad;

    // sticky error flag, only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (reject) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    // next-state: op decode in IDLE, RAM data capture in FETCH/PICK
    always_comb begin
        state_d = state_q;
        sp0_d   = sp0_q;
        sp1_d   = sp1_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        po_d    = po_q;
        done_d  = 1'b0;
        we      = 1'b0;
        wa      = sp1_q;
        wd      = vi;
        ra      = sp0_dec;
        unique case (state_q)
            IDLE: begin
                if (reject) begin
                    done_d = 1'b1;
                end else if (accept) begin
                    unique case (sop)
                        SS_PUSH: begin
                            we     = 1'b1;
                            wa     = sp1_q;
                            s_d    = vi;
                            sp0_d  = sp1_q;
                            sp1_d  = sp1_inc;
                            done_d = 1'b1;
                            if (!is_full) begin
                                cnt_d = cnt_q + (SSZ+1)'(1);
                            end
                        end
                        SS_SET: begin
                            we     = 1'b1;
                            wa     = sp0_q;
                            s_d    = vi;
                            done_d = 1'b1;
                        end
                        SS_POP: begin
                            sp1_d   = sp0_q;
                            sp0_d   = sp0_dec;
                            ra      = sp0_dec;
                            state_d = FETCH;
                            if (!is_empty) begin
                                cnt_d = cnt_q - (SSZ+1)'(1);
                            end
                        end
                        SS_PICK: begin
                            ra      = sp0_q - vi[SSZ-1:0];
                            state_d = PICK;
                        end
                    endcase
                end
            end
            FETCH: begin
                s_d     = is_empty ? '0 : rdata;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            PICK: begin
                po_d    = rdata;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sp0_q   <= SSZ'(DEPTH-1);
            sp1_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            po_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp0_q   <= sp0_d;
            sp1_q   <= sp1_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            po_q    <= po_d;
            done_q  <= done_d;
        end
    end

    assign rdy   = (state_q == IDLE);
    assign done  = done_q;
    assign s     = s_q;
    assign po    = po_q;
    assign sp0   = sp0_q;
    assign sp1   = sp1_q;
    assign cnt   = cnt_q;
    assign full  = is_full;
    assign empty = is_empty;

endmodule

// File: tb/tb_eforth1_stack.sv
// Self-checking bench for eforth1_stack: directed scenarios plus random ops
// against a queue-based stack model. Honours STACK_GUARD_EN like the design.
import eforth1_pkg::*;

module tb_eforth1_stack;

    localparam int DEPTH = 64;
    localparam int DSZ   = 16;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req = 1'b0;
    logic [1:0]     op  = 2'd0;
    logic [DSZ-1:0] vi  = '0;
    logic           rdy, done, full, empty, err;
    logic [DSZ-1:0] s, po;
    logic [5:0]     sp0, sp1;
    logic [6:0]     cnt;

    int total = 0;
    int bad   = 0;

    // behavioural model: the stack as a bounded queue of values
    int          q[$];
    int          msp0;
    int          ms;
    int          mpo;
    bit          mpo_ok;
    bit          merr;

    eforth1_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .vi    (vi),
        .rdy   (rdy),
        .done  (done),
        .s     (s),
        .po    (po),
        .sp0   (sp0),
        .sp1   (sp1),
        .cnt   (cnt),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        msp0 = DEPTH - 1; ms = 0; mpo = 0; mpo_ok = 1'b1; merr = 1'b0;
    endtask

    // drive one request; lat = cycles from accept edge to done, -1 on timeout
    task automatic issue(input sop_e o, input int v, output int lat);
        req = 1'b1; op = o; vi = DSZ'(v);
        @(posedge clk); #1;
        req = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic model_op(input sop_e o, input int v, output int el);
        int  n;
        bit  rej;
        n   = q.size();
        rej = GUARD && ((o == SS_PUSH && n == DEPTH) ||
                        ((o == SS_POP || o == SS_SET) && n == 0) ||
                        (o == SS_PICK && v >= n));
        if (rej) begin
            merr = 1'b1;
            el = 1;
            return;
        end
        case (o)
            SS_PUSH: begin
                q.push_back(v);
                if (q.size() > DEPTH) void'(q.pop_front());
                ms = v; msp0 = (msp0 + 1) % DEPTH; el = 1;
            end
            SS_SET: begin
                if (n > 0) q[$] = v;
                ms = v; el = 1;
            end
            SS_POP: begin
                if (n > 0) void'(q.pop_back());
                msp0 = (msp0 + DEPTH - 1) % DEPTH;
                ms = (q.size() > 0) ? q[$] : 0;
                el = 2;
            end
            default: begin
                if (v < n) begin
                    mpo = q[$ - v]; mpo_ok = 1'b1;
                end else begin
                    mpo_ok = 1'b0;
                end
                el = 2;
            end
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        total += 10;
        if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got %b want 1", rdy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        if (s !== 16'h0) begin bad++; $display("FAIL reset_s got %h want 0", s); end
        if (po !== 16'h0) begin bad++; $display("FAIL reset_po got %h want 0", po); end
        if (sp0 !== 6'd63) begin bad++; $display("FAIL reset_sp0 got %0d want 63", sp0); end
        if (sp1 !== 6'd0) begin bad++; $display("FAIL reset_sp1 got %0d want 0", sp1); end
        if (cnt !== 7'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got %b want 1", empty); end
        if (full !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", full); end
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_push();
        int lat;
        int vals[3] = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        foreach (vals[i]) begin
            issue(SS_PUSH, vals[i], lat);
            total++;
            if (lat !== 1) begin bad++; $display("FAIL push_lat got %0d want 1", lat); end
        end
        total += 4;
        if (s !== 16'h3333) begin bad++; $display("FAIL push_s got %h want 3333", s); end
        if (sp0 !== 6'd2) begin bad++; $display("FAIL push_sp0 got %0d want 2", sp0); end
        if (sp1 !== 6'd3) begin bad++; $display("FAIL push_sp1 got %0d want 3", sp1); end
        if (cnt !== 7'd3) begin bad++; $display("FAIL push_cnt got %0d want 3", cnt); end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got %b want 0", done); end
    endtask

    task automatic test_pop();
        int lat;
        req = 1'b1; op = SS_POP;
        @(posedge clk); #1;
        req = 1'b0;
        total += 2;
        if (rdy !== 1'b0) begin bad++; $display("FAIL pop_busy_rdy got %b want 0", rdy); end
        if (done !== 1'b0) begin bad++; $display("FAIL pop_busy_done got %b want 0", done); end
        @(posedge clk); #1;
        total += 5;
        if (done !== 1'b1) begin bad++; $display("FAIL pop_done got %b want 1", done); end
        if (rdy !== 1'b1) begin bad++; $display("FAIL pop_rdy got %b want 1", rdy); end
        if (s !== 16'h2222) begin bad++; $display("FAIL pop_s got %h want 2222", s); end
        if (sp0 !== 6'd1) begin bad++; $display("FAIL pop_sp0 got %0d want 1", sp0); end
        if (cnt !== 7'd2) begin bad++; $display("FAIL pop_cnt got %0d want 2", cnt); end
        issue(SS_POP, 0, lat);
        issue(SS_POP, 0, lat);
        total += 4;
        if (lat !== 2) begin bad++; $display("FAIL pop_lat got %0d want 2", lat); end
        if (empty !== 1'b1) begin bad++; $display("FAIL pop_empty got %b want 1", empty); end
        if (s !== 16'h0) begin bad++; $display("FAIL pop_s_zero got %h want 0", s); end
        if (sp0 !== 6'd63) begin bad++; $display("FAIL pop_sp0_wrap got %0d want 63", sp0); end
    endtask

    task automatic test_pick_set();
        int lat;
        do_reset();
        issue(SS_PUSH, 16'hA, lat);
        issue(SS_PUSH, 16'hB, lat);
        issue(SS_PUSH, 16'hC, lat);
        issue(SS_PICK, 2, lat);
        total += 3;
        if (lat !== 2) begin bad++; $display("FAIL pick_lat got %0d want 2", lat); end
        if (po !== 16'hA) begin bad++; $display("FAIL pick2_po got %h want 000a", po); end
        if (s !== 16'hC) begin bad++; $display("FAIL pick_s got %h want 000c", s); end
        issue(SS_SET, 16'h55, lat);
        total += 3;
        if (s !== 16'h55) begin bad++; $display("FAIL set_s got %h want 0055", s); end
        if (cnt !== 7'd3) begin bad++; $display("FAIL set_cnt got %0d want 3", cnt); end
        if (po !== 16'hA) begin bad++; $display("FAIL set_po_held got %h want 000a", po); end
        issue(SS_PICK, 0, lat);
        total++;
        if (po !== 16'h55) begin bad++; $display("FAIL pick0_po got %h want 0055", po); end
    endtask

`ifdef STACK_GUARD_EN
    task automatic test_guard();
        int lat;
        do_reset();
        issue(SS_POP, 0, lat);
        total += 4;
        if (lat !== 1) begin bad++; $display("FAIL guard_pop_lat got %0d want 1", lat); end
        if (err !== 1'b1) begin bad++; $display("FAIL guard_pop_err got %b want 1", err); end
        if (sp0 !== 6'd63) begin bad++; $display("FAIL guard_pop_sp0 got %0d want 63", sp0); end
        if (cnt !== 7'd0) begin bad++; $display("FAIL guard_pop_cnt got %0d want 0", cnt); end
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue(SS_PUSH, i + 100, lat);
        total += 2;
        if (full !== 1'b1) begin bad++; $display("FAIL guard_full got %b want 1", full); end
        if (err !== 1'b0) begin bad++; $display("FAIL guard_err_early got %b want 0", err); end
        issue(SS_PUSH, 16'hDEAD, lat);
        total += 5;
        if (lat !== 1) begin bad++; $display("FAIL guard_push_lat got %0d want 1", lat); end
        if (err !== 1'b1) begin bad++; $display("FAIL guard_push_err got %b want 1", err); end
        if (full !== 1'b1) begin bad++; $display("FAIL guard_push_full got %b want 1", full); end
        if (s !== 16'd163) begin bad++; $display("FAIL guard_push_s got %h want 00a3", s); end
        if (sp1 !== 6'd0) begin bad++; $display("FAIL guard_push_sp1 got %0d want 0", sp1); end
    endtask
`else
    task automatic test_wrap();
        int lat;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) issue(SS_PUSH, i, lat);
        total += 5;
        if (sp1 !== 6'd1) begin bad++; $display("FAIL wrap_sp1 got %0d want 1", sp1); end
        if (s !== 16'd64) begin bad++; $display("FAIL wrap_s got %0d want 64", s); end
        if (cnt !== 7'd64) begin bad++; $display("FAIL wrap_cnt got %0d want 64", cnt); end
        if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got %b want 1", full); end
        if (err !== 1'b0) begin bad++; $display("FAIL wrap_err got %b want 0", err); end
        issue(SS_PICK, 0, lat);
        total++;
        if (po !== 16'd64) begin bad++; $display("FAIL wrap_mem0 got %0d want 64", po); end
        issue(SS_PICK, 63, lat);
        total++;
        if (po !== 16'd1) begin bad++; $display("FAIL wrap_oldest got %0d want 1", po); end
        for (int i = 0; i <= DEPTH; i++) issue(SS_POP, 0, lat);
        total += 3;
        if (cnt !== 7'd0) begin bad++; $display("FAIL underflow_cnt got %0d want 0", cnt); end
        if (sp0 !== 6'd63) begin bad++; $display("FAIL underflow_sp0 got %0d want 63", sp0); end
        if (s !== 16'd0) begin bad++; $display("FAIL underflow_s got %0d want 0", s); end
    endtask
`endif

    task automatic test_busy();
        int lat;
        do_reset();
        issue(SS_PUSH, 7, lat);
        issue(SS_PUSH, 8, lat);
        req = 1'b1; op = SS_POP;
        @(posedge clk); #1;
        op = SS_PUSH; vi = 16'h99;
        @(posedge clk); #1;
        req = 1'b0;
        total += 3;
        if (done !== 1'b1) begin bad++; $display("FAIL busy_done got %b want 1", done); end
        if (s !== 16'd7) begin bad++; $display("FAIL busy_s got %h want 0007", s); end
        if (cnt !== 7'd1) begin bad++; $display("FAIL busy_cnt got %0d want 1", cnt); end
        @(posedge clk); #1;
        total += 2;
        if (done !== 1'b0) begin bad++; $display("FAIL busy_ignored_done got %b want 0", done); end
        if (cnt !== 7'd1) begin bad++; $display("FAIL busy_ignored_cnt got %0d want 1", cnt); end
        req = 1'b1; op = SS_POP;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total += 4;
        if (rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got %b want 1", rdy); end
        if (cnt !== 7'd0) begin bad++; $display("FAIL abort_cnt got %0d want 0", cnt); end
        if (sp0 !== 6'd63) begin bad++; $display("FAIL abort_sp0 got %0d want 63", sp0); end
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", done); end
    endtask

    task automatic test_random();
        int   lat, el, r, pw, v;
        sop_e o;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            pw = ((i / 150) % 2 == 0) ? 60 : 25;
            r  = $urandom_range(0, 99);
            if (r < pw) o = SS_PUSH;
            else if (r < pw + 15) o = SS_PICK;
            else if (r < pw + 25) o = SS_SET;
            else o = SS_POP;
            if (o == SS_PICK) v = $urandom_range(0, q.size() + 1);
            else v = $urandom & 16'hFFFF;
            total++;
            if (rdy !== 1'b1) begin bad++; $display("FAIL rnd_rdy op%0d got %b want 1", i, rdy); end
            model_op(o, v, el);
            issue(o, v, lat);
            total += 8;
            if (lat !== el) begin bad++; $display("FAIL rnd_lat op%0d got %0d want %0d", i, lat, el); end
            if (s !== DSZ'(ms)) begin bad++; $display("FAIL rnd_s op%0d got %h want %h", i, s, DSZ'(ms)); end
            if (sp0 !== 6'(msp0)) begin bad++; $display("FAIL rnd_sp0 op%0d got %0d want %0d", i, sp0, msp0); end
            if (sp1 !== 6'((msp0 + 1) % DEPTH)) begin bad++; $display("FAIL rnd_sp1 op%0d got %0d want %0d", i, sp1, (msp0 + 1) % DEPTH); end
            if (cnt !== 7'(q.size())) begin bad++; $display("FAIL rnd_cnt op%0d got %0d want %0d", i, cnt, q.size()); end
            if (full !== (q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full op%0d got %b", i, full); end
            if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_empty op%0d got %b", i, empty); end
            if (err !== merr) begin bad++; $display("FAIL rnd_err op%0d got %b want %b", i, err, merr); end
            if (mpo_ok) begin
                total++;
                if (po !== DSZ'(mpo)) begin bad++; $display("FAIL rnd_po op%0d got %h want %h", i, po, DSZ'(mpo)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_pick_set();
`ifdef STACK_GUARD_EN
        test_guard();
`else
        test_wrap();
`endif
        test_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
